fighter_action_scheduler: RTL and testbench
===========================================

// Module: fighter_action_scheduler
// PURPOSE
//  Sits between the per-button debouncers (one-cycle pulses) and the game engine. Latches each
//  player's move/attack requests, issues moves on the frame TICK and enforces per-player attack
//  cooldown. Arbitrates the single shared hit resolver round-robin between P1 and P2 over a
//  valid/ready handshake.
// PARAMETERS
//  COOLDOWN_TICKS  8  TICKs a player is blocked from attacking after an accepted attack (>=1)
//  CD_W            4  cooldown counter width; must hold COOLDOWN_TICKS
// PORTS
//  CLK         in   1  system clock; all logic on posedge CLK
//  RESET       in   1  synchronous, active-low reset
//  TICK        in   1  one-cycle frame strobe
//  P1_BTN      in   4  P1 debounced pulses: [0]=left [1]=right [2]=punch [3]=kick
//  P2_BTN      in   4  P2 debounced pulses, same mapping
//  P1_MOVE     out  2  00 none, 01 left, 10 right; valid for the one cycle after TICK
//  P2_MOVE     out  2  as P1_MOVE
//  P1_BUSY     out  1  P1 cooldown counter != 0
//  P2_BUSY     out  1  P2 cooldown counter != 0
//  ATK_VALID   out  1  attack offer to hit resolver
//  ATK_PLAYER  out  1  0=P1, 1=P2; stable while ATK_VALID
//  ATK_KIND    out  1  0=punch, 1=kick; stable while ATK_VALID
//  ATK_READY   in   1  hit resolver accepts; transfer = ATK_VALID & ATK_READY
// BEHAVIOUR
//  Reset (RESET==0 at edge): move/attack slots empty, cooldowns 0, arbiter IDLE, last-grant=P2
//   (P1 wins first tie); all outputs 0. Mid-offer reset drops ATK_VALID at that edge, no transfer.
//  Move slot (per player, 2b): left/right pulse writes slot, latest wins; same-cycle left+right
//   -> right. Move pulses accepted regardless of cooldown or arbitration.
//  Move issue: edge with TICK=1 registers slot onto Px_MOVE (visible next cycle, held 1 cycle)
//   and clears slot. A pulse in that same cycle is stored after the clear (issued next TICK).
//   Move outputs are 00 on every cycle not following a TICK.
//  Attack slot (per player, valid+kind): punch/kick pulse loads slot only if player not busy and
//   slot not currently offered; same-cycle punch+kick -> kick; otherwise new pulse overwrites.
//   Pulses while busy or while offered are dropped.
//  Cooldown: loads COOLDOWN_TICKS at transfer edge; decrements on TICK, saturates at 0; transfer
//   and TICK same edge -> load wins (no decrement that edge).
//  Arbiter FSM: IDLE -> OFFER when >=1 attack slot valid; single requester granted; two
//   requesters -> player != last-grant. OFFER drives ATK_VALID=1 with registered PLAYER/KIND
//   starting the cycle after the grant decision; holds until ATK_READY. On transfer edge: clear
//   that slot, load its cooldown, last-grant<=player, -> IDLE. Minimum spacing: one IDLE cycle
//   between offers. No timeout; ATK_READY held low stalls indefinitely, other player's attack
//   slot keeps latching but is not offered. ATK_READY ignored when ATK_VALID=0.
//  ATK_PLAYER/ATK_KIND read 0 when ATK_VALID=0.
// STRUCTURE
//  fighter_pkg: button bit indices, MOVE_NONE/LEFT/RIGHT codes, ATK_PUNCH/KICK codes.
//  Sub-module player_action_slot (move slot, attack slot, cooldown, BUSY), instantiated per
//   player. Arbiter FSM + round-robin pointer live in the top.
// TESTING
//  1 P1_BTN=0001 pulse, TICK 5 cycles later -> P1_MOVE=01 for exactly 1 cycle after TICK.
//  2 P1 punch, ATK_READY=1 -> ATK_VALID 1 cycle, PLAYER=0 KIND=0; P1_BUSY=1; punch on 3rd TICK
//    dropped; after 8 TICKs BUSY=0 and next punch offered.
//  3 P1 kick + P2 punch same cycle after reset -> P1 kick offered first, then P2 punch; repeat
//    -> P2 granted first (round-robin).
//  4 ATK_READY=0 for 20 cycles during offer, P1 punch pulses -> PLAYER/KIND stable, slot not
//    overwritten; ATK_READY=1 -> single transfer.
//  5 RESET=0 for 1 cycle mid-offer -> next cycle ATK_VALID=0, BUSY=0, MOVE=00, slots empty.
//  6 P2_BTN=0011 same cycle as TICK -> P2_MOVE=00 after that TICK, =10 after next TICK.

Source files
------------

// File: rtl/fighter_pkg.sv
// fighter_pkg: button bit positions, move/attack codes and arbiter states shared by the scheduler.
package fighter_pkg;
  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_PUNCH = 2;
  localparam int BTN_KICK  = 3;
  localparam logic [1:0] MOVE_NONE  = 2'b00;
  localparam logic [1:0] MOVE_LEFT  = 2'b01;
  localparam logic [1:0] MOVE_RIGHT = 2'b10;
  localparam logic ATK_PUNCH = 1'b0;
  localparam logic ATK_KICK  = 1'b1;
  typedef enum logic {ARB_IDLE, ARB_OFFER} arb_state_e;
endpackage

// File: rtl/player_action_slot.sv
// player_action_slot: one player's latched move request, pending attack and attack cooldown.
module player_action_slot
  import fighter_pkg::*;
#(
  parameter int COOLDOWN_TICKS = 8,
  parameter int CD_W = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic [3:0] btn,
  input  logic       offered,
  input  logic       xfer,
  output logic [1:0] move,
  output logic       busy,
  output logic       atk_valid,
  output logic       atk_kind
);
  logic [1:0] move_slot;
  logic [CD_W-1:0] cd;
  logic move_hit, atk_hit;
  assign busy = cd != '0;
  always_comb begin
    move_hit = btn[BTN_LEFT] | btn[BTN_RIGHT];
    atk_hit = (btn[BTN_PUNCH] | btn[BTN_KICK]) & ~busy & ~offered;
  end
  // a pulse arriving with TICK lands after the clear, so it waits for the next frame
  always_ff @(posedge CLK)
    if (!RESET) begin
      move      <= MOVE_NONE;
      move_slot <= MOVE_NONE;
      atk_valid <= 1'b0;
      atk_kind  <= ATK_PUNCH;
      cd        <= '0;
    end else begin
      move      <= TICK ? move_slot : MOVE_NONE;
      move_slot <= move_hit ? (btn[BTN_RIGHT] ? MOVE_RIGHT : MOVE_LEFT) : TICK ? MOVE_NONE : move_slot;
      atk_valid <= xfer ? 1'b0 : atk_hit ? 1'b1 : atk_valid;
      if (atk_hit) atk_kind <= btn[BTN_KICK] ? ATK_KICK : ATK_PUNCH;
      cd        <= xfer ? CD_W'(COOLDOWN_TICKS) : (TICK && busy) ? cd - 1'b1 : cd;
    end
endmodule

// File: rtl/fighter_action_scheduler.sv
// fighter_action_scheduler: per-player move/attack latching with round-robin access to the hit resolver.
module fighter_action_scheduler
  import fighter_pkg::*;
#(
  parameter int COOLDOWN_TICKS = 8,
  parameter int CD_W = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic [3:0] P1_BTN,
  input  logic [3:0] P2_BTN,
  output logic [1:0] P1_MOVE,
  output logic [1:0] P2_MOVE,
  output logic       P1_BUSY,
  output logic       P2_BUSY,
  output logic       ATK_VALID,
  output logic       ATK_PLAYER,
  output logic       ATK_KIND,
  input  logic       ATK_READY
);
  arb_state_e state, state_nx;
  logic player_q, player_nx, last_grant, xfer;
  logic [1:0] slot_valid, slot_kind, offered, slot_xfer;
  player_action_slot #(.COOLDOWN_TICKS(COOLDOWN_TICKS), .CD_W(CD_W)) u_p1 (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .btn(P1_BTN), .offered(offered[0]), .xfer(slot_xfer[0]),
    .move(P1_MOVE), .busy(P1_BUSY), .atk_valid(slot_valid[0]), .atk_kind(slot_kind[0])
  );
  player_action_slot #(.COOLDOWN_TICKS(COOLDOWN_TICKS), .CD_W(CD_W)) u_p2 (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .btn(P2_BTN), .offered(offered[1]), .xfer(slot_xfer[1]),
    .move(P2_MOVE), .busy(P2_BUSY), .atk_valid(slot_valid[1]), .atk_kind(slot_kind[1])
  );
  // on a tie the player who was not granted last time wins
  always_comb begin
    state_nx = state;
    player_nx = player_q;
    xfer = (state == ARB_OFFER) && ATK_READY;
    if (state == ARB_IDLE && |slot_valid) begin
      state_nx = ARB_OFFER;
      player_nx = &slot_valid ? ~last_grant : slot_valid[1];
    end else if (xfer) state_nx = ARB_IDLE;
    offered = (state == ARB_OFFER) ? (player_q ? 2'b10 : 2'b01) : 2'b00;
    slot_xfer = xfer ? offered : 2'b00;
    ATK_VALID = state == ARB_OFFER;
    ATK_PLAYER = ATK_VALID & player_q;
    ATK_KIND = ATK_VALID & slot_kind[player_q];
  end
  always_ff @(posedge CLK)
    if (!RESET) begin
      state      <= ARB_IDLE;
      player_q   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state    <= state_nx;
      player_q <= player_nx;
      if (xfer) last_grant <= player_q;
    end
endmodule

// File: tb/tb_fighter_action_scheduler.sv
// tb_fighter_action_scheduler: directed stimulus checked every cycle against a behavioural model.
module tb_fighter_action_scheduler;
  localparam int COOL = 8;
  logic CLK = 0, RESET = 0, TICK = 0, ATK_READY = 0;
  logic [3:0] P1_BTN = 0, P2_BTN = 0;
  logic [1:0] P1_MOVE, P2_MOVE;
  logic P1_BUSY, P2_BUSY, ATK_VALID, ATK_PLAYER, ATK_KIND;
  int checks = 0, failures = 0;

  fighter_action_scheduler #(.COOLDOWN_TICKS(COOL), .CD_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .P1_BTN(P1_BTN), .P2_BTN(P2_BTN),
    .P1_MOVE(P1_MOVE), .P2_MOVE(P2_MOVE), .P1_BUSY(P1_BUSY), .P2_BUSY(P2_BUSY),
    .ATK_VALID(ATK_VALID), .ATK_PLAYER(ATK_PLAYER), .ATK_KIND(ATK_KIND), .ATK_READY(ATK_READY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: per player pending move, shown move, cooldown count, pending attack; one offer at a time
  int m_slot[2], m_move[2], m_cd[2], m_op, m_last, mine;
  bit m_av[2], m_ak[2], ov[2], m_off, m_ok, xf;
  logic [3:0] b[2];
  always @(posedge CLK) begin
    b[0] = P1_BTN;
    b[1] = P2_BTN;
    if (!RESET) begin
      for (int p = 0; p < 2; p++) begin
        m_slot[p] = 0; m_move[p] = 0; m_cd[p] = 0; m_av[p] = 0; m_ak[p] = 0;
      end
      m_off = 0; m_op = 0; m_last = 1; m_ok = 1;
    end else begin
      xf = m_off && ATK_READY;
      ov = m_av;
      for (int p = 0; p < 2; p++) begin
        mine = (m_off && m_op == p) ? 1 : 0;
        m_move[p] = TICK ? m_slot[p] : 0;
        if (b[p][1]) m_slot[p] = 2;
        else if (b[p][0]) m_slot[p] = 1;
        else if (TICK) m_slot[p] = 0;
        if (xf && mine == 1) begin
          m_av[p] = 0;
          m_cd[p] = COOL;
        end else begin
          if ((b[p][2] || b[p][3]) && m_cd[p] == 0 && mine == 0) begin
            m_av[p] = 1;
            m_ak[p] = b[p][3];
          end
          if (TICK && m_cd[p] > 0) m_cd[p]--;
        end
      end
      if (m_off) begin
        if (xf) begin m_off = 0; m_last = m_op; end
      end else if (ov[0] || ov[1]) begin
        m_off = 1;
        m_op = (ov[0] && ov[1]) ? 1 - m_last : (ov[0] ? 0 : 1);
      end
    end
  end

  always @(negedge CLK)
    if (m_ok) begin
      chk("m_p1_move", {2'b0, P1_MOVE}, 4'(m_move[0]));
      chk("m_p2_move", {2'b0, P2_MOVE}, 4'(m_move[1]));
      chk("m_p1_busy", {3'b0, P1_BUSY}, {3'b0, m_cd[0] != 0});
      chk("m_p2_busy", {3'b0, P2_BUSY}, {3'b0, m_cd[1] != 0});
      chk("m_valid", {3'b0, ATK_VALID}, {3'b0, m_off});
      chk("m_player", {3'b0, ATK_PLAYER}, m_off ? 4'(m_op) : 4'd0);
      chk("m_kind", {3'b0, ATK_KIND}, m_off ? {3'b0, m_ak[m_op]} : 4'd0);
    end

  task automatic drive(input logic [3:0] b1, input logic [3:0] b2, input logic t);
    P1_BTN = b1; P2_BTN = b2; TICK = t;
    @(negedge CLK);
    P1_BTN = 0; P2_BTN = 0; TICK = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(0, 0, 1);
  endtask

  task automatic do_reset();
    RESET = 0;
    drive(0, 0, 0);
    RESET = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    // reset state and move issue
    do_reset();
    chk("rst_valid", {3'b0, ATK_VALID}, 0);
    chk("rst_move", {P1_MOVE, P2_MOVE}, 0);
    chk("rst_busy", {2'b0, P1_BUSY, P2_BUSY}, 0);
    drive(4'b0001, 0, 0);
    idle(4);
    drive(0, 0, 1);
    chk("t1_move_left", {2'b0, P1_MOVE}, 1);
    idle(1);
    chk("t1_move_gone", {2'b0, P1_MOVE}, 0);
    // single attack, cooldown, dropped punch while busy
    ATK_READY = 1;
    drive(4'b0100, 0, 0);
    chk("t2_not_yet", {3'b0, ATK_VALID}, 0);
    idle(1);
    chk("t2_offer", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0100);
    idle(1);
    chk("t2_one_cycle", {3'b0, ATK_VALID}, 0);
    chk("t2_busy", {3'b0, P1_BUSY}, 1);
    ticks(2);
    drive(4'b0100, 0, 1);
    ticks(4);
    chk("t2_busy_7", {3'b0, P1_BUSY}, 1);
    ticks(1);
    chk("t2_busy_8", {3'b0, P1_BUSY}, 0);
    idle(2);
    chk("t2_dropped", {3'b0, ATK_VALID}, 0);
    drive(4'b0100, 0, 0);
    idle(1);
    chk("t2_reoffer", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0100);
    idle(1);
    // round robin
    do_reset();
    drive(4'b1000, 4'b0100, 0);
    idle(1);
    chk("t3_first_p1", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0101);
    idle(1);
    chk("t3_gap", {3'b0, ATK_VALID}, 0);
    idle(1);
    chk("t3_then_p2", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0110);
    idle(1);
    ticks(COOL);
    drive(4'b0100, 0, 0);
    idle(2);
    ticks(COOL);
    drive(4'b1000, 4'b1000, 0);
    idle(1);
    chk("t3_rr_p2", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0111);
    idle(2);
    chk("t3_rr_p1", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0101);
    idle(1);
    // stall with pulses that must be dropped
    do_reset();
    ATK_READY = 0;
    drive(4'b0100, 0, 0);
    idle(1);
    repeat (20) drive(4'b1000, 0, 0);
    chk("t4_stable", {1'b0, ATK_VALID, ATK_PLAYER, ATK_KIND}, 4'b0100);
    ATK_READY = 1;
    idle(1);
    chk("t4_xfer", {3'b0, ATK_VALID}, 0);
    idle(2);
    chk("t4_single", {3'b0, ATK_VALID}, 0);
    // reset while offering
    do_reset();
    ATK_READY = 0;
    drive(4'b0100, 4'b0001, 0);
    idle(1);
    drive(0, 0, 1);
    chk("t5_pre", {ATK_VALID, ATK_PLAYER, P2_MOVE}, 4'b1001);
    ATK_READY = 1;
    do_reset();
    ATK_READY = 0;
    chk("t5_after", {ATK_VALID, P1_BUSY, P1_MOVE[0], P2_MOVE[0]}, 0);
    idle(2);
    chk("t5_empty", {3'b0, ATK_VALID}, 0);
    drive(0, 0, 1);
    chk("t5_moves", {P1_MOVE, P2_MOVE}, 0);
    // left+right pulse together with TICK
    drive(0, 4'b0011, 1);
    chk("t6_first", {2'b0, P2_MOVE}, 0);
    idle(1);
    drive(0, 0, 1);
    chk("t6_right", {2'b0, P2_MOVE}, 2);
    idle(1);
    chk("t6_gone", {2'b0, P2_MOVE}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
